// File: rtl/sbus_uart_tx_if.sv
// -----------------------------------------------------------------------------
// sbus_uart_tx_if
// Byte handshake and serial-line bundle for the S.BUS UART transmitter.
//   uart_tx_en    : transmit enable (gates acceptance of new bytes only)
//   uart_tx_data  : byte to send
//   uart_tx_valid : uart_tx_data is valid
//   uart_tx_ready : transmitter can accept a byte this cycle
//   uart_tx_busy  : frame in progress
//   uart_txd      : serial line
// Modports: master = byte source, slave = transmitter.
// -----------------------------------------------------------------------------
interface sbus_uart_tx_if;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_tx_valid;
  logic       uart_tx_ready;
  logic       uart_tx_busy;
  logic       uart_txd;

  modport master (
    output uart_tx_en,
    output uart_tx_data,
    output uart_tx_valid,
    input  uart_tx_ready,
    input  uart_tx_busy,
    input  uart_txd
  );

  modport slave (
    input  uart_tx_en,
    input  uart_tx_data,
    input  uart_tx_valid,
    output uart_tx_ready,
    output uart_tx_busy,
    output uart_txd
  );
endinterface

// File: rtl/sbus_uart_tx.sv
// -----------------------------------------------------------------------------
// sbus_uart_tx
// UART transmitter for the S.BUS link, 8E2 framing: start bit, 8 data bits
// LSB first, even parity, two stop bits. One byte is accepted per
// valid/ready handshake and serialised at BIT_RATE.
//
// Ports:
//   clk    : system clock
//   resetn : synchronous, active-low reset
//   tx_if  : sbus_uart_tx_if.slave (enable, data, valid, ready, busy, txd)
//
// Build option: define SBUS_TX_INVERT_EN to drive the native inverted S.BUS
// line level (idle low). Timing and handshake are unchanged.
// -----------------------------------------------------------------------------
module sbus_uart_tx #(
  parameter int BIT_RATE = 100_000,
  parameter int CLK_HZ   = 50_000_000
) (
  input  logic           clk,
  input  logic           resetn,
  sbus_uart_tx_if.slave  tx_if
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int FRAME_BITS     = 12;
  localparam int CNT_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);

`ifdef SBUS_TX_INVERT_EN
  localparam logic TXD_INV = 1'b1;
`else
  localparam logic TXD_INV = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even parity: data plus parity bit carries an even number of ones.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  // Map a frame (mark = 1) level onto the physical line level.
  function automatic logic line_level(input logic frame_lvl);
    return frame_lvl ^ TXD_INV;
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_r;
  logic             stop_r;
  logic [7:0]       shift_r;
  logic             parity_r;
  logic             txd_r;
  logic             busy_r;

  logic ready_s;
  logic transfer_s;
  logic last_s;

  assign ready_s    = (state_r == IDLE) && tx_if.uart_tx_en;
  assign transfer_s = ready_s && tx_if.uart_tx_valid;
  // Terminal count of the per-bit cycle counter.
  assign last_s     = (cnt_r == CNT_LAST);

  assign tx_if.uart_tx_ready = ready_s;
  assign tx_if.uart_tx_busy  = busy_r;
  assign tx_if.uart_txd      = txd_r;

  // Frame FSM: each non-idle state holds for CYCLES_PER_BIT cycles; the line
  // level is registered together with the state transition.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      bit_r    <= 3'd0;
      stop_r   <= 1'b0;
      shift_r  <= 8'h00;
      parity_r <= 1'b0;
      txd_r    <= line_level(1'b1);
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (transfer_s) begin
            shift_r  <= tx_if.uart_tx_data;
            parity_r <= even_parity(tx_if.uart_tx_data);
            cnt_r    <= '0;
            bit_r    <= 3'd0;
            stop_r   <= 1'b0;
            txd_r    <= line_level(1'b0);
            busy_r   <= 1'b1;
            state_r  <= START;
          end else begin
            txd_r    <= line_level(1'b1);
          end
        end
        START: begin
          if (last_s) begin
            cnt_r   <= '0;
            txd_r   <= line_level(shift_r[0]);
            state_r <= DATA;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        DATA: begin
          if (last_s) begin
            cnt_r <= '0;
            if (bit_r == 3'd7) begin
              txd_r   <= line_level(parity_r);
              state_r <= PARITY;
            end else begin
              // Next data bit is shift_r[1]; present it as we shift.
              shift_r <= {1'b0, shift_r[7:1]};
              txd_r   <= line_level(shift_r[1]);
              bit_r   <= bit_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        PARITY: begin
          if (last_s) begin
            cnt_r   <= '0;
            txd_r   <= line_level(1'b1);
            state_r <= STOP;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        STOP: begin
          if (last_s) begin
            cnt_r <= '0;
            if (stop_r) begin
              stop_r  <= 1'b0;
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else begin
              stop_r  <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          bit_r   <= 3'd0;
          stop_r  <= 1'b0;
          txd_r   <= line_level(1'b1);
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sbus_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_sbus_uart_tx
// Directed self-checking bench for sbus_uart_tx (default 500 cycles per bit).
// Expected line bits are queued when a byte is offered and popped as the
// line is sampled at the first and last cycle of every bit period.
// -----------------------------------------------------------------------------
module tb_sbus_uart_tx;

`ifdef SBUS_TX_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif
  localparam logic IDLE_LVL = 1'b1 ^ INV;
  localparam int   CPB      = 500;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_fail;
  logic exp_q[$];

  sbus_uart_tx_if bus ();

  sbus_uart_tx #(
    .BIT_RATE (100_000),
    .CLK_HZ   (50_000_000)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .tx_if  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame bit k (0 = start) in frame (non-inverted) level.
  function automatic logic [11:0] frame_bits(input logic [7:0] d);
    logic [11:0] f;
    f[0]     = 1'b0;
    f[8:1]   = d;
    f[9]     = ^d;
    f[11:10] = 2'b11;
    return f;
  endfunction

  // Offer byte d and check the whole frame bit by bit. With hold set, valid
  // stays high and the data input changes to nd during the frame.
  task automatic run_frame(input logic [7:0] d, input logic [11:0] pat,
                           input bit hold, input logic [7:0] nd);
    logic e;
    bus.uart_tx_data  = d;
    bus.uart_tx_valid = 1'b1;
    #1;
    chk("pre_ready", bus.uart_tx_ready, 1'b1);
    chk("pre_txd_idle", bus.uart_txd, IDLE_LVL);
    for (int k = 0; k < 12; k++) exp_q.push_back(pat[k]);
    tick();
    if (!hold) bus.uart_tx_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      e = exp_q[0];
      chk($sformatf("bit%0d_head", k), bus.uart_txd, e ^ INV);
      if (k == 0) begin
        chk("busy_start", bus.uart_tx_busy, 1'b1);
        chk("ready_start", bus.uart_tx_ready, 1'b0);
      end
      if (hold && k == 3) bus.uart_tx_data = nd;
      repeat (CPB - 1) tick();
      e = exp_q.pop_front();
      chk($sformatf("bit%0d_tail", k), bus.uart_txd, e ^ INV);
      tick();
    end
    chk("ready_end", bus.uart_tx_ready, 1'b1);
    chk("busy_end", bus.uart_tx_busy, 1'b0);
    chk("txd_end_idle", bus.uart_txd, IDLE_LVL);
  endtask

  initial begin
    logic [7:0] v55;
    n_cmp  = 0;
    n_fail = 0;
    v55    = 8'h55;
    resetn            = 1'b0;
    bus.uart_tx_en    = 1'b1;
    bus.uart_tx_valid = 1'b0;
    bus.uart_tx_data  = 8'h00;
    repeat (3) tick();
    chk("rst_txd", bus.uart_txd, IDLE_LVL);
    chk("rst_busy", bus.uart_tx_busy, 1'b0);
    chk("rst_ready", bus.uart_tx_ready, 1'b1);
    resetn = 1'b1;
    tick();

    // Reference patterns written out by hand for 0xA5 and 0x00.
    run_frame(8'hA5, 12'b110101001010, 1'b0, 8'h00);
    run_frame(8'h07, frame_bits(8'h07), 1'b0, 8'h00);
    chk("parity_07", frame_bits(8'h07) >> 9 & 12'd1, 1'b1);
    run_frame(8'h00, 12'b110000000000, 1'b0, 8'h00);

    // Back-to-back with valid held; data changes mid-frame to the next byte.
    run_frame(8'h0F, frame_bits(8'h0F), 1'b1, 8'hF0);
    run_frame(8'hF0, frame_bits(8'hF0), 1'b0, 8'h00);

    // Enable low: nothing is accepted while valid waits.
    bus.uart_tx_en    = 1'b0;
    bus.uart_tx_data  = 8'h3C;
    bus.uart_tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      repeat (40) tick();
      chk("en0_ready", bus.uart_tx_ready, 1'b0);
      chk("en0_txd", bus.uart_txd, IDLE_LVL);
      chk("en0_busy", bus.uart_tx_busy, 1'b0);
    end
    bus.uart_tx_en = 1'b1;
    run_frame(8'h3C, frame_bits(8'h3C), 1'b0, 8'h00);

    // Reset during data bit 3 of 0x55 aborts the frame.
    bus.uart_tx_data  = 8'h55;
    bus.uart_tx_valid = 1'b1;
    tick();
    bus.uart_tx_valid = 1'b0;
    repeat (4 * CPB + 200) tick();
    chk("abort_bit3", bus.uart_txd, v55[3] ^ INV);
    resetn = 1'b0;
    tick();
    chk("abort_txd", bus.uart_txd, IDLE_LVL);
    chk("abort_busy", bus.uart_tx_busy, 1'b0);
    chk("abort_ready", bus.uart_tx_ready, 1'b1);
    resetn = 1'b1;
    tick();
    chk("post_abort_txd", bus.uart_txd, IDLE_LVL);
    run_frame(8'h55, frame_bits(8'h55), 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sbus_uart_tx.md
Name: sbus_uart_tx

Overview:
- UART transmitter for the S.BUS serial link, 8E2 framing: 1 start, 8 data bits LSB first, even parity, 2 stop bits.
- Drives S.BUS frames from the FPGA, e.g. for loopback against the receiver or servo/telemetry output.
- Accepts one byte per valid/ready handshake and serialises it at BIT_RATE.

Parameters:
- BIT_RATE, 100_000: line bit rate in bits/s.
- CLK_HZ, 50_000_000: clk frequency in Hz.
- CYCLES_PER_BIT (localparam), CLK_HZ/BIT_RATE = 500: clk cycles per bit.
- FRAME_BITS (localparam), 12: start + 8 data + parity + 2 stop.

Ports:
- clk  input  1  system clock.
- resetn  input  1  synchronous, active-low reset.
- uart_tx_en  input  1  transmit enable; gates acceptance of new bytes only.
- uart_tx_data  input  8  byte to send.
- uart_tx_valid  input  1  uart_tx_data is valid.
- uart_tx_ready  output  1  block can accept a byte this cycle.
- uart_tx_busy  output  1  frame in progress.
- uart_txd  output  1  serial line, registered.

Behaviour:
- Reset is synchronous on clk, active-low resetn. Reset values:
  - uart_txd = 1 (line idle/mark level).
  - uart_tx_ready = 1, uart_tx_busy = 0.
  - FSM in IDLE; cycle and bit counters cleared.
- Handshake: a transfer occurs on a clk edge where uart_tx_valid && uart_tx_ready. uart_tx_ready = (state == IDLE) && uart_tx_en.
- On transfer at edge T:
  - Latch data into a shift register.
  - Compute parity = ^data (even parity: data + parity has an even count of ones).
  - Enter START.
  - uart_txd = 0 from edge T+1. busy = 1 and ready = 0 from edge T+1.
- FSM states and transitions. Each bit lasts exactly CYCLES_PER_BIT cycles; the cycle counter counts 0..CYCLES_PER_BIT-1 and advances state/bit on terminal count.
  - IDLE: txd = 1. Go to START on transfer.
  - START: txd = 0, one bit time. Go to DATA.
  - DATA: txd = shift[0]; shift right at each bit end. Bit counter 0..7. Go to PARITY after bit 7.
  - PARITY: txd = latched parity. Go to STOP.
  - STOP: txd = 1, two bit times (stop counter 0..1). Then go to IDLE.
- Frame length is exactly 12 × CYCLES_PER_BIT = 6000 cycles, from edge T+1 to ready reasserting at edge T+6001.
- Back-to-back: if valid is held high, the next start bit begins at T+6002. Exactly one idle cycle separates frames. No other idle insertion.
- Input handling during a frame: uart_tx_data and uart_tx_valid are ignored while busy. Changes to the input data never corrupt the frame in flight.
- uart_tx_en deasserted mid-frame: the current frame completes; no new byte is accepted until enable returns.
- Reset mid-frame: the frame is aborted. uart_txd = 1 at the next edge, and all state returns to reset values. No partial stop sequence is emitted.
- Counter width: $clog2(CYCLES_PER_BIT); no wrap beyond terminal count.

Optional Feature:
- Macro SBUS_TX_INVERT_EN.
- Defined: uart_txd is the logical inverse of the frame level. Idle = 0, start = 1, and data/parity/stop bits are inverted. The reset value of uart_txd becomes 0. This matches the native inverted S.BUS line without an external inverter.
- Undefined: non-inverted output as specified above. Timing and handshake are identical in both builds.

Test Plan:
- Reset, then send 0xA5 → uart_txd sequence per 500-cycle bit: 0,1,0,1,0,0,1,0,1,0,1,1. Ready high again 6000 cycles after txd falls.
- Send 0x07 (three ones) → parity bit 1. Send 0x00 → parity 0 and frame 0,0×8,0,1,1.
- Hold valid with bytes 0x0F then 0xF0 → second start bit exactly 6001 cycles after the first. Data change during frame 1 has no effect on frame 1.
- uart_tx_en = 0 with valid = 1 → ready = 0 and txd stays 1 indefinitely. Raising en → transfer next cycle.
- Assert resetn = 0 during data bit 3 of 0x55 → txd = 1, busy = 0, ready = 1 on the next edge. A fresh 0x55 after release transmits cleanly.
- With SBUS_TX_INVERT_EN defined, send 0xA5 → txd = 1,0,1,0,1,1,0,1,0,1,0,0, and idle/reset level is 0.
